// File: rtl/mc_pkg.sv
// Shared constants and types for the Monte-Carlo path streamer.
package mc_pkg;

    localparam int PATH_W      = 12;
    localparam int DATA_LENGTH = 256;
    localparam int DAY         = 8;
    localparam int ADDR_W      = 11;
    localparam int IDX_W       = 8;
    localparam int DAY_W       = 3;
    localparam int LCNT_W      = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;
    typedef logic [PATH_W-1:0] path_t;

    // DATA_LENGTH is a power of two, so the day/index pair concatenates into the address.
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [DAY_W-1:0] day,
                                                  input logic [IDX_W-1:0] idx);
        return {day, idx};
    endfunction

endpackage

// File: rtl/mc_path_ram.sv
// Single-port synchronous sample buffer, one-cycle read latency, write has priority.
module mc_path_ram
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PATH_W-1:0] i_wdata,
    output logic [PATH_W-1:0] o_rdata
);

    path_t r_mem [DAY*DATA_LENGTH];

    // NOTE: no reset on the storage array so it maps onto block RAM; contents are always loaded before use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/mc_path_streamer.sv
// Buffers DAY x DATA_LENGTH price-path samples and streams one day per pass to the pricing core,
// following the core's replay / next-day resend protocol.
module mc_path_streamer
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [PATH_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              run,
    input  logic              resend,
    output logic              core_start,
    output logic [PATH_W-1:0] path,
    output logic              path_valid,
    output logic [DAY_W-1:0]  day_idx,
    output logic              pass,
    output logic              done
);

    state_t              r_state;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [IDX_W-1:0]    r_rd_idx;
    logic [DAY_W-1:0]    r_day;
    logic                r_pass;
    logic                r_core_start;
    logic                r_done;
    logic                r_rd_v;
    logic                r_path_valid;
    path_t               r_path;

    logic                w_full;
    logic                w_ld_ready;
    logic                w_we;
    logic                w_last_day;
    logic                w_last_idx;
    logic [ADDR_W-1:0]   w_addr;
    path_t               w_rdata;

    assign w_full     = r_lcnt[ADDR_W];
    assign w_ld_ready = (r_state == IDLE) && !w_full;
    assign w_we       = ld_valid && w_ld_ready;
    assign w_last_day = (r_day == DAY_W'(DAY - 1));
    assign w_last_idx = (r_rd_idx == IDX_W'(DATA_LENGTH - 1));
    assign w_addr     = w_we ? r_lcnt[ADDR_W-1:0] : rd_addr(r_day, r_rd_idx);

    mc_path_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (ld_data),
        .o_rdata (w_rdata)
    );

    // Load counter saturates at DAY*DATA_LENGTH; its top bit doubles as the buffer-full flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lcnt <= '0;
        end else if (w_we) begin
            r_lcnt <= r_lcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rd_idx     <= '0;
            r_day        <= '0;
            r_pass       <= 1'b0;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (run && w_full) begin
                        r_state      <= STREAM;
                        r_core_start <= 1'b1;
                        r_done       <= 1'b0;
                        r_day        <= '0;
                        r_pass       <= 1'b0;
                        r_rd_idx     <= '0;
                    end
                end
                STREAM, WAIT: begin
                    // A resend mid-stream aborts the pass and takes the same decision as in WAIT.
                    if (resend) begin
                        r_rd_idx <= '0;
                        if (!r_pass) begin
                            r_pass  <= 1'b1;
                            r_state <= STREAM;
                        end else if (!w_last_day) begin
                            r_day   <= r_day + 1'b1;
                            r_pass  <= 1'b0;
                            r_state <= STREAM;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_state == STREAM) begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                        if (w_last_idx) begin
                            r_state <= WAIT;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The read issued in an aborting cycle is dropped; only the one already in the RAM completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_v       <= 1'b0;
            r_path_valid <= 1'b0;
            r_path       <= '0;
        end else begin
            r_rd_v       <= (r_state == STREAM) && !resend;
            r_path_valid <= r_rd_v;
            if (r_rd_v) begin
                r_path <= w_rdata;
            end
        end
    end

    assign ld_ready   = w_ld_ready;
    assign core_start = r_core_start;
    assign path       = r_path;
    assign path_valid = r_path_valid;
    assign day_idx    = r_day;
    assign pass       = r_pass;
    assign done       = r_done;

endmodule

// File: tb/tb_mc_path_streamer.sv
// Scoreboard bench for mc_path_streamer: load, stream, replay/advance, abort, completion and async reset.
module tb_mc_path_streamer;
    import mc_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic [PATH_W-1:0] ld_data;
    logic              ld_ready;
    logic              run;
    logic              resend;
    logic              core_start;
    logic [PATH_W-1:0] path;
    logic              path_valid;
    logic [DAY_W-1:0]  day_idx;
    logic              pass;
    logic              done;

    typedef struct packed {
        logic [DAY_W-1:0] day;
        logic             pass;
        path_t            path;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en     = 1'b0;
    int   n_chk     = 0;
    int   n_err     = 0;
    int   valid_cnt = 0;

    always #5 clk = ~clk;

    mc_path_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .run        (run),
        .resend     (resend),
        .core_start (core_start),
        .path       (path),
        .path_valid (path_valid),
        .day_idx    (day_idx),
        .pass       (pass),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: outputs change on posedge, so the negedge sees them settled.
    exp_t e;
    always @(negedge clk) begin
        if (!reset && path_valid) begin
            valid_cnt++;
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("path", path, e.path);
                    check("day_idx", day_idx, e.day);
                    check("pass", pass, e.pass);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int d, input int p, input int first);
        exp_t x;
        for (int i = first; i < DATA_LENGTH; i++) begin
            x.day  = DAY_W'(d);
            x.pass = p[0];
            x.path = path_t'(d * DATA_LENGTH + i);
            sb_q.push_back(x);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    task automatic pulse_resend();
        resend = 1'b1;
        tick();
        resend = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stale;
        bit found;
        bit cs_seen;
        bit pv_seen;

        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        run      = 1'b0;
        resend   = 1'b0;
        repeat (3) tick();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_path_valid", path_valid, 0);
        check("rst_path", path, 0);
        check("rst_core_start", core_start, 0);
        check("rst_done", done, 0);
        check("rst_day", day_idx, 0);
        check("rst_pass", pass, 0);
        reset = 1'b0;
        tick();

        // Fill the buffer with value = address.
        for (int i = 0; i < DAY * DATA_LENGTH; i++) begin
            if (i == DAY * DATA_LENGTH - 1) check("ld_ready_before_last", ld_ready, 1);
            ld_valid = 1'b1;
            ld_data  = path_t'(i);
            tick();
        end
        check("ld_ready_after_full", ld_ready, 0);
        ld_data = 12'hABC;
        tick();
        ld_valid = 1'b0;
        check("ld_ready_stays_low", ld_ready, 0);

        // First pass of day 0.
        valid_cnt = 0;
        push_pass(0, 0, 0);
        sb_en = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("core_start_pulse", core_start, 1);
        check("valid_before_data", path_valid, 0);
        tick();
        check("core_start_one_cycle", core_start, 0);
        check("valid_latency", path_valid, 0);
        tick();
        check("first_valid", path_valid, 1);
        check("first_path", path, 0);
        drain("drain_d0p0");
        repeat (3) tick();
        check("count_d0p0", valid_cnt, DATA_LENGTH);
        check("wait_valid_low", path_valid, 0);
        check("wait_path_held", path, 12'h0FF);

        // Replay and advance through every day.
        for (int k = 1; k < 2 * DAY; k++) begin
            valid_cnt = 0;
            push_pass(k / 2, k % 2, 0);
            pulse_resend();
            drain("drain_pass");
            repeat (3) tick();
            check("count_pass", valid_cnt, DATA_LENGTH);
            check("wait_valid_low_k", path_valid, 0);
            check("wait_path_held_k", path, (k / 2) * DATA_LENGTH + DATA_LENGTH - 1);
        end
        pulse_resend();
        tick();
        check("done_set", done, 1);
        check("done_valid_low", path_valid, 0);
        check("done_day", day_idx, DAY - 1);

        // Restart from DONE without reload, then abort day 0 pass 0 at sample 100.
        valid_cnt = 0;
        push_pass(0, 0, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("restart_core_start", core_start, 1);
        check("restart_done_clear", done, 0);
        n = 0;
        while (valid_cnt < 100 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach", valid_cnt, 100);
        sb_en = 1'b0;
        sb_q.delete();
        resend = 1'b1;
        @(posedge clk);
        #1;
        resend = 1'b0;
        stale = 0;
        found = 1'b0;
        n     = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (path_valid) begin
                if (path == 0) found = 1'b1;
                else stale++;
            end
        end
        check("abort_restart_found", found, 1);
        check("abort_stale_le1", (stale <= 1), 1);
        check("abort_restart_pass", pass, 1);
        check("abort_restart_day", day_idx, 0);
        valid_cnt = 0;
        push_pass(0, 1, 1);
        sb_en = 1'b1;
        drain("drain_abort");
        repeat (3) tick();
        check("count_abort", valid_cnt, DATA_LENGTH - 1);

        // Walk to day 3 with mid-stream resends, then reset while streaming.
        sb_en = 1'b0;
        repeat (5) begin
            pulse_resend();
            repeat (2) tick();
        end
        check("walk_day", day_idx, 3);
        check("walk_pass", pass, 0);
        repeat (10) tick();
        check("mid_stream_valid", path_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_path_valid", path_valid, 0);
        check("async_path", path, 0);
        check("async_day", day_idx, 0);
        check("async_pass", pass, 0);
        check("async_core_start", core_start, 0);
        check("async_done", done, 0);
        check("async_ld_ready", ld_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Run without reload must be ignored.
        run = 1'b1;
        tick();
        run = 1'b0;
        cs_seen = core_start;
        pv_seen = path_valid;
        repeat (10) begin
            tick();
            cs_seen |= core_start;
            pv_seen |= path_valid;
        end
        check("no_start_after_reset", cs_seen, 0);
        check("no_valid_after_reset", pv_seen, 0);
        check("ld_ready_after_reset", ld_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
